// File: rtl/tdo_bit_fetch.sv
// TDO bit fetch: turns per-bit shift requests into a serial TDO stream
// fed from an 8-bit synchronous vector RAM through a two-byte prefetch buffer.
`timescale 1ns/1ps
module tdo_bit_fetch (
    input  logic        clk_scan,
    input  logic        reset,
    input  logic        load,
    input  logic [23:0] start_adr,
    input  logic        shift,
    output logic        rd_en,
    output logic [20:0] rd_adr,
    input  logic [7:0]  rd_data,
    output logic        tdo,
    output logic        ready,
    output logic        underrun,
    output logic [23:0] bit_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        FETCH1,
        RUN
    } state_t;

    state_t      state;
    logic [20:0] wadr;
    logic [2:0]  ptr;
    logic [7:0]  cur;
    logic [7:0]  nxt;
    logic        nxt_valid;
    // pend1: read issued last edge, RAM samples it on this edge
    // pend2: read data is on rd_data now and lands in nxt on this edge
    logic        pend1;
    logic        pend2;

    // Fetch sequencing, prefetch buffer and serial shift, all in one FSM
    always_ff @(posedge clk_scan or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wadr      <= '0;
            ptr       <= '0;
            cur       <= '0;
            nxt       <= '0;
            nxt_valid <= 1'b0;
            pend1     <= 1'b0;
            pend2     <= 1'b0;
            rd_en     <= 1'b0;
            rd_adr    <= '0;
            tdo       <= 1'b1;
            ready     <= 1'b0;
            underrun  <= 1'b0;
            bit_cnt   <= '0;
        end else if (load) begin
            state     <= FETCH0;
            wadr      <= start_adr[23:3];
            ptr       <= start_adr[2:0];
            rd_en     <= 1'b1;
            rd_adr    <= start_adr[23:3];
            bit_cnt   <= '0;
            underrun  <= 1'b0;
            ready     <= 1'b0;
            nxt_valid <= 1'b0;
            pend1     <= 1'b0;
            pend2     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    rd_en <= 1'b0;
                    if (shift) underrun <= 1'b1;
                end
                FETCH0: begin
                    rd_en  <= 1'b1;
                    rd_adr <= wadr + 21'd1;
                    state  <= FETCH1;
                    if (shift) underrun <= 1'b1;
                end
                FETCH1: begin
                    cur   <= rd_data;
                    ready <= 1'b1;
                    rd_en <= 1'b0;
                    pend2 <= 1'b1;
                    state <= RUN;
                    if (shift) underrun <= 1'b1;
                end
                RUN: begin
                    if (pend1) begin
                        pend1 <= 1'b0;
                        pend2 <= 1'b1;
                        rd_en <= 1'b0;
                    end
                    if (pend2) begin
                        pend2     <= 1'b0;
                        nxt       <= rd_data;
                        nxt_valid <= 1'b1;
                    end
                    if (shift) begin
                        tdo     <= cur[ptr];
                        ptr     <= ptr + 3'd1;
                        bit_cnt <= bit_cnt + 24'd1;
                        if (ptr == 3'd7) begin
                            // nxt may still be arriving when the start bit is 7
                            cur       <= nxt_valid ? nxt : rd_data;
                            wadr      <= wadr + 21'd1;
                            rd_en     <= 1'b1;
                            rd_adr    <= wadr + 21'd2;
                            nxt_valid <= 1'b0;
                            pend1     <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdo_bit_fetch.sv
// Directed testbench for tdo_bit_fetch with a small sparse RAM model.
`timescale 1ns/1ps
module tb_tdo_bit_fetch;

    logic        clk_scan;
    logic        reset;
    logic        load;
    logic [23:0] start_adr;
    logic        shift;
    logic        rd_en;
    logic [20:0] rd_adr;
    logic [7:0]  rd_data;
    logic        tdo;
    logic        ready;
    logic        underrun;
    logic [23:0] bit_cnt;

    int errors;
    int checks;
    logic [20:0] rdq[$];

    tdo_bit_fetch dut (
        .clk_scan (clk_scan),
        .reset    (reset),
        .load     (load),
        .start_adr(start_adr),
        .shift    (shift),
        .rd_en    (rd_en),
        .rd_adr   (rd_adr),
        .rd_data  (rd_data),
        .tdo      (tdo),
        .ready    (ready),
        .underrun (underrun),
        .bit_cnt  (bit_cnt)
    );

    initial clk_scan = 1'b0;
    always #5 clk_scan = ~clk_scan;

    function automatic logic [7:0] ram_rd(input logic [20:0] a);
        case (a)
            21'h000010: return 8'hA5;
            21'h000011: return 8'h3C;
            21'h000012: return 8'hFF;
            21'h1FFFFF: return 8'h5A;
            21'h000000: return 8'hC3;
            21'h000001: return 8'h0F;
            default:    return 8'h00;
        endcase
    endfunction

    // synchronous RAM with one cycle of read latency, plus read log
    always @(posedge clk_scan) begin
        if (rd_en) begin
            rd_data <= ram_rd(rd_adr);
            rdq.push_back(rd_adr);
        end
    end

    task automatic do_load(input logic [23:0] a);
        load      = 1'b1;
        start_adr = a;
        @(negedge clk_scan);
        load = 1'b0;
        @(negedge clk_scan);
        @(negedge clk_scan);
    endtask

    task automatic shift_bits(input int n, output logic [15:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            shift = 1'b1;
            @(negedge clk_scan);
            v[i] = tdo;
        end
        shift = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk_scan);
        checks++;
        if (tdo !== 1'b1 || ready !== 1'b0 || underrun !== 1'b0 ||
            rd_en !== 1'b0 || rd_adr !== 21'd0 || bit_cnt !== 24'd0) begin
            errors++;
            $display("FAIL reset_state got tdo=%b rdy=%b und=%b rd_en=%b adr=%h cnt=%0d exp 1 0 0 0 0 0",
                     tdo, ready, underrun, rd_en, rd_adr, bit_cnt);
        end
        reset = 1'b0;
        @(negedge clk_scan);
    endtask

    task automatic test_premature;
        load      = 1'b1;
        start_adr = 24'h000080;
        @(negedge clk_scan);
        load  = 1'b0;
        shift = 1'b1;
        @(negedge clk_scan);
        shift = 1'b0;
        checks++;
        if (underrun !== 1'b1 || tdo !== 1'b1 || bit_cnt !== 24'd0) begin
            errors++;
            $display("FAIL premature got und=%b tdo=%b cnt=%0d exp und=1 tdo=1 cnt=0",
                     underrun, tdo, bit_cnt);
        end
        repeat (2) @(negedge clk_scan);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky got=%b exp=1", underrun);
        end
        load = 1'b1;
        @(negedge clk_scan);
        load = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear got=%b exp=0", underrun);
        end
        repeat (3) @(negedge clk_scan);
    endtask

    task automatic test_basic;
        logic [15:0] v;
        logic        rdy_bad;
        rdq.delete();
        load      = 1'b1;
        start_adr = 24'h000080;
        @(negedge clk_scan);
        load = 1'b0;
        checks++;
        if (rd_en !== 1'b1 || rd_adr !== 21'h10 || ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_e0 got rd_en=%b adr=%h rdy=%b exp 1 010 0",
                     rd_en, rd_adr, ready);
        end
        @(negedge clk_scan);
        checks++;
        if (rd_en !== 1'b1 || rd_adr !== 21'h11 || ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_e1 got rd_en=%b adr=%h rdy=%b exp 1 011 0",
                     rd_en, rd_adr, ready);
        end
        @(negedge clk_scan);
        checks++;
        if (ready !== 1'b1 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_e2 got rdy=%b rd_en=%b exp 1 0", ready, rd_en);
        end
        v       = '0;
        rdy_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            shift = 1'b1;
            @(negedge clk_scan);
            v[i] = tdo;
            if (ready !== 1'b1) rdy_bad = 1'b1;
        end
        shift = 1'b0;
        checks++;
        if (v !== 16'h3CA5) begin
            errors++;
            $display("FAIL basic_tdo got=%h exp=3ca5", v);
        end
        checks++;
        if (bit_cnt !== 24'd16 || underrun !== 1'b0 || rdy_bad !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got cnt=%0d und=%b rdy_drop=%b exp 16 0 0",
                     bit_cnt, underrun, rdy_bad);
        end
        checks++;
        if (rdq.size() < 3 || rdq[0] !== 21'h10 || rdq[1] !== 21'h11 ||
            rdq[2] !== 21'h12) begin
            errors++;
            $display("FAIL basic_reads got n=%0d first=%h exp 010 011 012",
                     rdq.size(), (rdq.size() > 0) ? rdq[0] : 21'h0);
        end
        repeat (2) @(negedge clk_scan);
    endtask

    task automatic test_unaligned;
        logic [15:0] v;
        do_load(24'h000085);
        shift_bits(5, v);
        checks++;
        if (v[4:0] !== 5'b00101 || bit_cnt !== 24'd5) begin
            errors++;
            $display("FAIL unaligned got tdo=%b cnt=%0d exp tdo=00101 cnt=5",
                     v[4:0], bit_cnt);
        end
        repeat (2) @(negedge clk_scan);
    endtask

    task automatic test_wrap;
        logic [15:0] v;
        rdq.delete();
        do_load(24'hFFFFF8);
        shift_bits(16, v);
        checks++;
        if (v !== 16'hC35A) begin
            errors++;
            $display("FAIL wrap_tdo got=%h exp=c35a", v);
        end
        checks++;
        if (rdq.size() < 3 || rdq[0] !== 21'h1FFFFF || rdq[1] !== 21'h0 ||
            rdq[2] !== 21'h1) begin
            errors++;
            $display("FAIL wrap_reads got n=%0d first=%h exp 1fffff 000000 000001",
                     rdq.size(), (rdq.size() > 0) ? rdq[0] : 21'h0);
        end
        repeat (2) @(negedge clk_scan);
    endtask

    task automatic test_load_mid_run;
        logic [15:0] v;
        do_load(24'h000080);
        shift_bits(4, v);
        checks++;
        if (v[3:0] !== 4'b0101) begin
            errors++;
            $display("FAIL midrun_pre got=%b exp=0101", v[3:0]);
        end
        shift     = 1'b1;
        load      = 1'b1;
        start_adr = 24'h000090;
        @(negedge clk_scan);
        shift = 1'b0;
        load  = 1'b0;
        checks++;
        if (bit_cnt !== 24'd0 || underrun !== 1'b0 || ready !== 1'b0 ||
            rd_adr !== 21'h12) begin
            errors++;
            $display("FAIL midrun_load got cnt=%0d und=%b rdy=%b adr=%h exp 0 0 0 012",
                     bit_cnt, underrun, ready, rd_adr);
        end
        @(negedge clk_scan);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL midrun_rdy_low got=%b exp=0", ready);
        end
        @(negedge clk_scan);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_rdy_high got=%b exp=1", ready);
        end
        shift_bits(8, v);
        checks++;
        if (v[7:0] !== 8'hFF || bit_cnt !== 24'd8) begin
            errors++;
            $display("FAIL midrun_stream got tdo=%h cnt=%0d exp ff 8", v[7:0], bit_cnt);
        end
        repeat (2) @(negedge clk_scan);
    endtask

    task automatic test_async_reset;
        do_load(24'h00008F);
        shift = 1'b1;
        @(negedge clk_scan);
        checks++;
        if (tdo !== 1'b0 || rd_en !== 1'b1 || bit_cnt !== 24'd1) begin
            errors++;
            $display("FAIL areset_pre got tdo=%b rd_en=%b cnt=%0d exp 0 1 1",
                     tdo, rd_en, bit_cnt);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (tdo !== 1'b1 || ready !== 1'b0 || rd_en !== 1'b0 ||
            bit_cnt !== 24'd0 || rd_adr !== 21'd0) begin
            errors++;
            $display("FAIL areset_now got tdo=%b rdy=%b rd_en=%b cnt=%0d adr=%h exp 1 0 0 0 0",
                     tdo, ready, rd_en, bit_cnt, rd_adr);
        end
        shift = 1'b0;
        @(negedge clk_scan);
        reset = 1'b0;
        shift = 1'b1;
        @(negedge clk_scan);
        shift = 1'b0;
        checks++;
        if (underrun !== 1'b1 || bit_cnt !== 24'd0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle got und=%b cnt=%0d rdy=%b exp 1 0 0",
                     underrun, bit_cnt, ready);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        load      = 1'b0;
        shift     = 1'b0;
        start_adr = '0;
        rd_data   = '0;
        test_reset();
        test_premature();
        test_basic();
        test_unaligned();
        test_wrap();
        test_load_mid_run();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
